// File: rtl/d_pop_arbiter.sv
// Round-robin merge of two FIFO read ports into one valid/ready stream
// through a 2-entry skid buffer, with per-channel delivery counters.
module d_pop_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       active_in,
    input  logic       empty_fifo_D0,
    input  logic       empty_fifo_D1,
    input  logic [5:0] data_out_D0,
    input  logic [5:0] data_out_D1,
    input  logic       ready_in,
    output logic       D0_pop,
    output logic       D1_pop,
    output logic [5:0] data_out,
    output logic       channel_out,
    output logic       valid_out,
    output logic [7:0] count_D0,
    output logic [7:0] count_D1,
    output logic       busy_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic       ch;
        logic [5:0] data;
    } entry_t;

    state_t     state_q;
    state_t     state_d;
    entry_t     buf0_q;
    entry_t     buf1_q;
    entry_t     wr_entry;
    logic [1:0] occ_q;
    logic       inflight_q;
    logic       inflight_ch_q;
    logic       last_q;
    logic       deliver;
    logic [2:0] load;
    logic       pop_ok;
    logic       pick_d1;
    logic       both_empty;

    assign valid_out   = (occ_q != 2'd0);
    assign data_out    = buf0_q.data;
    assign channel_out = buf0_q.ch;
    assign busy_out    = (state_q != IDLE);
    assign deliver     = valid_out & ready_in;
    assign both_empty  = empty_fifo_D0 & empty_fifo_D1;

    // Words already committed (buffered or returning) minus the one leaving now
    assign load   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, deliver};
    assign pop_ok = (load < 3'd2);

    assign wr_entry = inflight_ch_q ? {1'b1, data_out_D1}
                                    : {1'b0, data_out_D0};

    always_comb begin
        D0_pop  = 1'b0;
        D1_pop  = 1'b0;
        pick_d1 = !empty_fifo_D1 && (empty_fifo_D0 || !last_q);
        if (reset && state_q == RUN && pop_ok && !both_empty) begin
            D1_pop = pick_d1;
            D0_pop = !pick_d1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (active_in && !both_empty)
                    state_d = RUN;
            end
            RUN: begin
                if (!active_in)
                    state_d = DRAIN;
                else if (both_empty && occ_q == 2'd0 && !inflight_q)
                    state_d = IDLE;
            end
            DRAIN: begin
                if (active_in)
                    state_d = RUN;
                else if (occ_q == 2'd0 && !inflight_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            occ_q         <= 2'd0;
            inflight_q    <= 1'b0;
            inflight_ch_q <= 1'b0;
            last_q        <= 1'b1;
            buf0_q        <= '0;
            buf1_q        <= '0;
            count_D0      <= 8'd0;
            count_D1      <= 8'd0;
        end else begin
            state_q       <= state_d;
            inflight_q    <= D0_pop | D1_pop;
            inflight_ch_q <= D1_pop;
            if (D0_pop | D1_pop)
                last_q <= D1_pop;
            occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, deliver};
            case ({inflight_q, deliver})
                2'b10: begin
                    if (occ_q == 2'd0)
                        buf0_q <= wr_entry;
                    else
                        buf1_q <= wr_entry;
                end
                2'b01: buf0_q <= buf1_q;
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_q <= wr_entry;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= wr_entry;
                    end
                end
                default: ;
            endcase
            if (deliver) begin
                if (buf0_q.ch)
                    count_D1 <= count_D1 + 8'd1;
                else
                    count_D0 <= count_D0 + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_d_pop_arbiter.sv
// Scoreboard bench for d_pop_arbiter: FIFO models feed the DUT, a monitor
// checks arbitration rules, pop legality, word order and counters.
module tb_d_pop_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       active_in;
    logic       empty_fifo_D0 = 1'b1;
    logic       empty_fifo_D1 = 1'b1;
    logic [5:0] data_out_D0 = 6'h00;
    logic [5:0] data_out_D1 = 6'h00;
    logic       ready_in;
    logic       D0_pop;
    logic       D1_pop;
    logic [5:0] data_out;
    logic       channel_out;
    logic       valid_out;
    logic [7:0] count_D0;
    logic [7:0] count_D1;
    logic       busy_out;

    always #5 clk = ~clk;

    d_pop_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .active_in    (active_in),
        .empty_fifo_D0(empty_fifo_D0),
        .empty_fifo_D1(empty_fifo_D1),
        .data_out_D0  (data_out_D0),
        .data_out_D1  (data_out_D1),
        .ready_in     (ready_in),
        .D0_pop       (D0_pop),
        .D1_pop       (D1_pop),
        .data_out     (data_out),
        .channel_out  (channel_out),
        .valid_out    (valid_out),
        .count_D0     (count_D0),
        .count_D1     (count_D1),
        .busy_out     (busy_out)
    );

    int checks = 0;
    int errors = 0;

    logic [5:0] f0[$];
    logic [5:0] f1[$];
    logic [6:0] expq[$];
    logic [6:0] dlog[$];
    logic [6:0] want[$];
    int         popc0[$];

    int         cyc = 0;
    int         pipe = 0;
    int         m_cnt0 = 0;
    int         m_cnt1 = 0;
    bit         tb_last = 1'b1;
    bit         rst_prev = 1'b0;
    bit         hold = 1'b0;
    bit         nx0 = 1'b0;
    bit         nx1 = 1'b0;
    bit         acc;
    bit         exp_d1;
    logic [5:0] nx0_d = 6'h00;
    logic [5:0] nx1_d = 6'h00;
    logic [6:0] prev_word = 7'h00;
    logic [6:0] w;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // FIFO read ports: data appears the cycle after a pop, noise otherwise
    always @(posedge clk) begin
        data_out_D0   <= nx0 ? nx0_d : 6'($urandom);
        data_out_D1   <= nx1 ? nx1_d : 6'($urandom);
        empty_fifo_D0 <= (f0.size() == 0);
        empty_fifo_D1 <= (f1.size() == 0);
    end

    always @(negedge clk) begin
        #1;
        cyc++;
        if (!reset) begin
            chk("pop_in_reset", int'({D0_pop, D1_pop}), 0);
            if (rst_prev) begin
                chk("rst_valid", int'(valid_out), 0);
                chk("rst_data", int'(data_out), 0);
                chk("rst_chan", int'(channel_out), 0);
                chk("rst_cnt0", int'(count_D0), 0);
                chk("rst_cnt1", int'(count_D1), 0);
                chk("rst_busy", int'(busy_out), 0);
            end
            expq.delete();
            pipe     = 0;
            m_cnt0   = 0;
            m_cnt1   = 0;
            tb_last  = 1'b1;
            hold     = 1'b0;
            nx0      = 1'b0;
            nx1      = 1'b0;
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            acc = valid_out && ready_in;
            chk("count_D0", int'(count_D0), m_cnt0 % 256);
            chk("count_D1", int'(count_D1), m_cnt1 % 256);
            if (hold)
                chk("hold", int'({valid_out, channel_out, data_out}),
                    int'({1'b1, prev_word}));
            nx0 = 1'b0;
            nx1 = 1'b0;
            if (D0_pop || D1_pop) begin
                chk("pop_both", int'(D0_pop && D1_pop), 0);
                chk("pop_busy", int'(busy_out), 1);
                chk("pop_capacity", int'((pipe - int'(acc)) < 2), 1);
                chk("pop_empty", int'((D0_pop && empty_fifo_D0) ||
                                      (D1_pop && empty_fifo_D1)), 0);
                exp_d1 = !empty_fifo_D1 && (empty_fifo_D0 || !tb_last);
                chk("round_robin", int'(D1_pop), int'(exp_d1));
                if (D1_pop && f1.size() > 0) begin
                    nx1   = 1'b1;
                    nx1_d = f1.pop_front();
                    expq.push_back({1'b1, nx1_d});
                end else if (D0_pop && f0.size() > 0) begin
                    nx0   = 1'b1;
                    nx0_d = f0.pop_front();
                    expq.push_back({1'b0, nx0_d});
                end
                pipe++;
                tb_last = D1_pop;
                if (D0_pop)
                    popc0.push_back(cyc);
            end
            if (acc) begin
                if (expq.size() == 0) begin
                    chk("spurious_word", 1, 0);
                end else begin
                    w = expq.pop_front();
                    chk("word", int'({channel_out, data_out}), int'(w));
                    dlog.push_back({channel_out, data_out});
                    if (w[6])
                        m_cnt1++;
                    else
                        m_cnt0++;
                    pipe--;
                end
            end
            hold      = valid_out && !ready_in;
            prev_word = {channel_out, data_out};
        end
    end

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while (n < budget && !(busy_out == 1'b0 && f0.size() == 0 &&
                               f1.size() == 0 && expq.size() == 0)) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk(name, int'(busy_out == 1'b0 && f0.size() == 0 &&
                       f1.size() == 0 && expq.size() == 0), 1);
    endtask

    task automatic check_log(string name);
        chk({name, "_len"}, dlog.size(), want.size());
        for (int i = 0; i < want.size() && i < dlog.size(); i++)
            chk(name, int'(dlog[i]), int'(want[i]));
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        active_in = 1'b0;
        ready_in  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("post_rst_valid", int'(valid_out), 0);
        chk("post_rst_busy", int'(busy_out), 0);

        // single channel, full throughput
        @(negedge clk);
        active_in = 1'b1;
        ready_in  = 1'b1;
        dlog.delete();
        popc0.delete();
        f0.push_back(6'h05);
        f0.push_back(6'h06);
        f0.push_back(6'h07);
        wait_idle("t1_idle", 50);
        chk("t1_pops", popc0.size(), 3);
        if (popc0.size() == 3)
            chk("t1_consecutive", popc0[2] - popc0[0], 2);
        want = '{7'h05, 7'h06, 7'h07};
        check_log("t1_log");
        chk("t1_count_D0", int'(count_D0), 3);

        // both channels alternate, D0 first after reset
        do_reset(1);
        dlog.delete();
        f0.push_back(6'h11);
        f0.push_back(6'h12);
        f1.push_back(6'h21);
        f1.push_back(6'h22);
        wait_idle("t2_idle", 50);
        want = '{7'h11, 7'h61, 7'h12, 7'h62};
        check_log("t2_log");

        // back-pressure: only two words may be committed
        do_reset(1);
        ready_in = 1'b0;
        dlog.delete();
        popc0.delete();
        for (int i = 0; i < 4; i++)
            f0.push_back(6'(8'h31 + i));
        repeat (10) @(negedge clk);
        #2;
        chk("t3_pops", popc0.size(), 2);
        chk("t3_valid", int'(valid_out), 1);
        chk("t3_data", int'(data_out), 'h31);
        chk("t3_chan", int'(channel_out), 0);
        @(negedge clk);
        ready_in = 1'b1;
        wait_idle("t3_idle", 50);
        want = '{7'h31, 7'h32, 7'h33, 7'h34};
        check_log("t3_log");

        // active_in drops in the same cycle as a pop
        do_reset(1);
        dlog.delete();
        popc0.delete();
        f0.push_back(6'h01);
        f0.push_back(6'h02);
        f0.push_back(6'h03);
        for (int n = 0; n < 20 && !D0_pop; n++)
            @(negedge clk);
        chk("t4_pop_seen", int'(D0_pop), 1);
        active_in = 1'b0;
        @(negedge clk);
        #2;
        chk("t4_drain_busy", int'(busy_out), 1);
        repeat (8) @(negedge clk);
        #2;
        chk("t4_idle_busy", int'(busy_out), 0);
        chk("t4_pops", popc0.size(), 1);
        chk("t4_fifo_left", f0.size(), 2);
        want = '{7'h01};
        check_log("t4_log");
        @(negedge clk);
        active_in = 1'b1;
        wait_idle("t4_idle", 50);
        want = '{7'h01, 7'h02, 7'h03};
        check_log("t4_log_all");

        // D1 counter wrap with D0 counter untouched
        do_reset(1);
        dlog.delete();
        f0.push_back(6'h0a);
        f0.push_back(6'h0b);
        f0.push_back(6'h0c);
        wait_idle("t5_d0_idle", 50);
        @(negedge clk);
        for (int i = 0; i < 256; i++)
            f1.push_back(6'($urandom));
        wait_idle("t5_idle", 1000);
        chk("t5_count_D1", int'(count_D1), 0);
        chk("t5_count_D0", int'(count_D0), 3);
        chk("t5_delivered", dlog.size(), 259);

        // reset with two words buffered
        do_reset(1);
        ready_in = 1'b0;
        dlog.delete();
        for (int i = 0; i < 4; i++)
            f0.push_back(6'(8'h11 + i));
        repeat (10) @(negedge clk);
        #2;
        chk("t6_buffered", int'(valid_out), 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #2;
        chk("t6_valid", int'(valid_out), 0);
        chk("t6_busy", int'(busy_out), 0);
        chk("t6_cnt0", int'(count_D0), 0);
        chk("t6_nopop", int'({D0_pop, D1_pop}), 0);
        @(negedge clk);
        ready_in = 1'b1;
        wait_idle("t6_idle", 50);
        want = '{7'h13, 7'h14};
        check_log("t6_log");

        // random traffic, qualifier toggling, back-pressure, rare resets
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && f0.size() < 6)
                f0.push_back(6'($urandom));
            if ($urandom_range(0, 3) == 0 && f1.size() < 6)
                f1.push_back(6'($urandom));
            active_in = ($urandom_range(0, 7) != 0);
            ready_in  = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        reset     = 1'b1;
        active_in = 1'b1;
        ready_in  = 1'b1;
        wait_idle("rand_flush", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_pop_arbiter.md
D_POP_ARBITER -- requirements
Module: d_pop_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-003 SHALL have port active_in  input  1  link-active qualifier, driven from the full_logic active_out.
REQ-004 SHALL have port empty_fifo_D0  input  1  D0 FIFO empty flag; reflects occupancy after the previous edge.
REQ-005 SHALL have port empty_fifo_D1  input  1  D1 FIFO empty flag; same timing as D0.
REQ-006 SHALL have port data_out_D0  input  6  D0 FIFO read data; valid the cycle after D0_pop.
REQ-007 SHALL have port data_out_D1  input  6  D1 FIFO read data; valid the cycle after D1_pop.
REQ-008 SHALL have port ready_in  input  1  sink accepts the current word when valid_out=1.
REQ-009 SHALL have port D0_pop  output  1  pop request to the D0 FIFO.
REQ-010 SHALL have port D1_pop  output  1  pop request to the D1 FIFO.
REQ-011 SHALL have port data_out  output  6  merged output word.
REQ-012 SHALL have port channel_out  output  1  source of data_out (0=D0, 1=D1).
REQ-013 SHALL have port valid_out  output  1  data_out/channel_out hold a valid word.
REQ-014 SHALL have ports count_D0 and count_D1  output  8 each  words delivered per channel.
REQ-015 SHALL have port busy_out  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL contain a 2-entry output buffer; each entry holds 7 bits: channel plus data.
REQ-017 SHALL set valid_out=1 exactly when buffer occupancy >0; data_out/channel_out SHALL show the oldest entry.
REQ-018 SHALL count a word as delivered on a cycle with valid_out=1 and ready_in=1; that entry leaves at the edge.
REQ-019 SHALL keep data_out/channel_out stable while valid_out=1 and ready_in=0.
REQ-020 SHALL set inflight=1 in the cycle after any pop; the returning word SHALL be written into the buffer at that cycle's edge.
REQ-021 SHALL allow a pop only when occupancy + inflight - (valid_out & ready_in) < 2, so steady ready_in=1 sustains 1 word/cycle.
REQ-022 SHALL never assert Dx_pop while empty_fifo_Dx=1, and SHALL never assert D0_pop and D1_pop in the same cycle.
REQ-023 SHALL arbitrate round-robin: with both FIFOs non-empty, serve the channel not served last; with one non-empty, serve it; last-served updates only on a pop.
REQ-024 SHALL implement an FSM with states IDLE, RUN and DRAIN.
- IDLE->RUN: active_in=1 and at least one FIFO non-empty; no pop in the transition cycle.
- RUN: pops per REQ-021..023.
- RUN->DRAIN: active_in=0.
- RUN->IDLE: both FIFOs empty, occupancy 0, inflight 0.
- DRAIN: no pops; the buffer and any inflight word still deliver.
- DRAIN->IDLE: occupancy 0 and inflight 0.
- DRAIN->RUN: active_in=1 reasserts.
REQ-025 SHALL increment count_Dx by 1 per delivered word of channel x, wrapping 255->0 without a flag.
REQ-026 SHALL, if active_in falls in the same cycle as a pop, still capture and deliver the inflight word.
REQ-027 SHALL compute all outputs except D0_pop/D1_pop from registers; Dx_pop SHALL be a combinational function of the state and registered counts plus the empty flags and ready_in.

Reset
REQ-028 SHALL, while reset=0 at an edge, go to IDLE, clear the buffer, inflight and counters, and set last-served=D1 (D0 wins first).
REQ-029 SHALL, during reset, drive D0_pop=0, D1_pop=0, valid_out=0, data_out=6'h00, channel_out=0, count_D0=count_D1=0, busy_out=0.
REQ-030 SHALL discard the buffered and inflight words on reset mid-operation, with no pop in the first cycle after reset is released.

Verification
REQ-031 Bench SHALL cover: D0 holds 3 words (0x05,0x06,0x07), D1 empty, active_in=1, ready_in=1 -> D0_pop for 3 consecutive cycles, outputs 0x05,0x06,0x07 with channel_out=0, count_D0=3.
REQ-032 Bench SHALL cover: both FIFOs hold 2 words (D0:0x11,0x12; D1:0x21,0x22), ready_in=1 -> output order 0x11,0x21,0x12,0x22, alternating channel_out.
REQ-033 Bench SHALL cover: ready_in=0 with D0 holding 4 words -> exactly 2 pops, then no pops; valid_out=1 with data_out held; on ready_in=1 all 4 words delivered in order.
REQ-034 Bench SHALL cover: active_in dropped in the same cycle as a pop -> DRAIN, the inflight word delivered, no further pops, IDLE once empty, busy_out=0.
REQ-035 Bench SHALL cover: 256 D1 words delivered -> count_D1 wraps to 0 with count_D0 unchanged.
REQ-036 Bench SHALL cover: reset=0 asserted with 2 words buffered -> next cycle valid_out=0, counts 0, IDLE; no pop in the first cycle after release.
